// File: rtl/outer_pkg.sv
// Shared constants, state encoding and helpers for the outer-loop digit sequencer.
package outer_pkg;

  localparam int SIZE  = 3072;
  localparam int RADIX = 54;
  localparam int BW    = SIZE + 2;
  localparam int NDIG  = (BW + RADIX - 1) / RADIX;
  localparam int PADW  = NDIG * RADIX;
  localparam int LAT   = 6;
  localparam int IDXW  = 6;
  localparam int TOPW  = BW - RADIX * (NDIG - 1);
  localparam int CNTW  = $clog2(LAT + 1);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIG - 1);
  localparam logic [CNTW-1:0] LAT_CNT  = CNTW'(LAT);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DRAIN,
    DONE
  } state_e;

  // The top digit is only TOPW bits wide; padding makes it a normal zero-extended digit.
  function automatic logic [PADW-1:0] pad_b(input logic [BW-1:0] v);
    return {{(PADW - BW){1'b0}}, v};
  endfunction

endpackage

// File: rtl/digit_shift_reg.sv
// Holds the padded multiplier and exposes its lowest RADIX-bit digit; each advance drops one digit.
module digit_shift_reg
  import outer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             advance,
  input  logic             clear,
  input  logic [BW-1:0]    b,
  output logic [RADIX-1:0] digit
);

  logic [PADW-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (clear) begin
      sr_d = '0;
    end else if (load) begin
      sr_d = pad_b(b);
    end else if (advance) begin
      sr_d = sr_q >> RADIX;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  // Low digit comes straight from the register, so il_bi is a flop output and holds between advances.
  assign digit = sr_q[RADIX-1:0];

endmodule

// File: rtl/outer_loop_ctrl.sv
// Steps the inner multiply datapath through every digit of B, one launch per LAT cycles,
// strobes the accumulator as each result becomes valid, and drains the pipeline on abort.
module outer_loop_ctrl
  import outer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [BW-1:0]    b,
  output logic             busy,
  output logic             done,
  output logic             il_en,
  output logic [RADIX-1:0] il_bi,
  output logic             acc_en,
  output logic [IDXW-1:0]  acc_idx,
  output logic             acc_first,
  output logic             acc_last
);

  state_e          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            il_en_q, il_en_d;
  logic            acc_en_q, acc_en_d;
  logic [IDXW-1:0] acc_idx_q, acc_idx_d;
  logic            acc_first_q, acc_first_d;
  logic            acc_last_q, acc_last_d;
  logic            sr_load, sr_adv, sr_clr;
  logic            kill;

  assign kill = abort && ((state_q == ISSUE) || (state_q == WAIT));

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    il_en_d     = 1'b0;
    acc_en_d    = 1'b0;
    acc_idx_d   = '0;
    acc_first_d = 1'b0;
    acc_last_d  = 1'b0;
    sr_load     = 1'b0;
    sr_adv      = 1'b0;
    sr_clr      = 1'b0;

    if (kill) begin
      // Pulses and digit drop next cycle; busy stays up while in-flight work settles.
      state_d = DRAIN;
      cnt_d   = LAT_CNT;
      busy_d  = 1'b1;
      sr_clr  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          busy_d = 1'b0;
          if (start && !abort) begin
            sr_load = 1'b1;
            idx_d   = '0;
            cnt_d   = LAT_CNT;
            il_en_d = 1'b1;
            busy_d  = 1'b1;
            state_d = ISSUE;
          end
        end

        ISSUE: begin
          cnt_d   = cnt_q - CNTW'(1);
          state_d = WAIT;
        end

        WAIT: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNTW'(1);
          end
          if (cnt_q == CNTW'(1)) begin
            acc_en_d    = 1'b1;
            acc_idx_d   = idx_q;
            acc_first_d = (idx_q == '0);
            acc_last_d  = (idx_q == LAST_IDX);
            if (idx_q != LAST_IDX) begin
              il_en_d = 1'b1;
              sr_adv  = 1'b1;
              idx_d   = idx_q + IDXW'(1);
              cnt_d   = LAT_CNT;
            end
          end
          // Counter only reaches zero after the final digit's strobe, keeping done off the acc_en cycle.
          if (cnt_q == '0) begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end

        DRAIN: begin
          if (cnt_q == CNTW'(1)) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - CNTW'(1);
          end
        end

        DONE: begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end

        default: begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      il_en_q     <= 1'b0;
      acc_en_q    <= 1'b0;
      acc_idx_q   <= '0;
      acc_first_q <= 1'b0;
      acc_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      il_en_q     <= il_en_d;
      acc_en_q    <= acc_en_d;
      acc_idx_q   <= acc_idx_d;
      acc_first_q <= acc_first_d;
      acc_last_q  <= acc_last_d;
    end
  end

  digit_shift_reg u_digits (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (sr_load),
    .advance (sr_adv),
    .clear   (sr_clr),
    .b       (b),
    .digit   (il_bi)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign il_en     = il_en_q;
  assign acc_en    = acc_en_q;
  assign acc_idx   = acc_idx_q;
  assign acc_first = acc_first_q;
  assign acc_last  = acc_last_q;

endmodule
